state_fifo: RTL and testbench

//  Parametrised multi-entry buffer for permutation states.

---
 rtl/state_fifo.sv | 111 +++++++++++
 tb/tb_state_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/state_fifo.sv
// Multi-entry valid/ready buffer for full permutation states, with flush, occupancy and a sticky
// misuse flag. Read data is taken combinationally from storage at the read pointer.
module state_fifo #(
  parameter int unsigned WIDTH = 320,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             pending_q, pending_d;
  logic             push, pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign in_ready_o  = !full_o;
  assign out_valid_o = !empty_o;
  assign count_o     = count_q;
  assign err_o       = err_q;
  assign out_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    // A request left pending last cycle must still be present now.
    pending_d = in_valid_i && !in_ready_o;
    err_d     = err_q || (pending_q && !in_valid_i);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (push) begin
        err_d = 1'b1;
      end
    end else begin
      if (push) begin
        wr_ptr_d = inc_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = inc_ptr(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  a_count_range : assert property (@(posedge clock_i) disable iff (reset_i)
    count_q <= CNT_W'(DEPTH));

  a_ptr_distance : assert property (@(posedge clock_i) disable iff (reset_i)
    ((int'(wr_ptr_q) - int'(rd_ptr_q) + int'(DEPTH)) % int'(DEPTH))
      == (int'(count_q) % int'(DEPTH)));

endmodule

// File: tb/tb_state_fifo.sv
// Self-checking bench for state_fifo: table-driven fill/drain/handshake vectors on a depth-4
// instance, plus directed reset, flush, misuse and depth-3 wrap sequences.
module tb_state_fifo;

  localparam int unsigned W = 320;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, full, empty, err;
  logic [W-1:0] out_data;
  logic [2:0]   count;

  logic         w_in_valid, w_out_ready;
  logic [W-1:0] w_in_data;
  logic         w_in_ready, w_out_valid, w_full, w_empty, w_err;
  logic [W-1:0] w_out_data;
  logic [1:0]   w_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  state_fifo #(.WIDTH(W), .DEPTH(4)) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty),
    .err_o      (err)
  );

  state_fifo #(.WIDTH(W), .DEPTH(3)) dut3 (
    .clock_i    (clk),
    .reset_i    (rst),
    .flush_i    (1'b0),
    .in_valid_i (w_in_valid),
    .in_ready_o (w_in_ready),
    .in_data_i  (w_in_data),
    .out_valid_o(w_out_valid),
    .out_ready_i(w_out_ready),
    .out_data_o (w_out_data),
    .count_o    (w_count),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .err_o      (w_err)
  );

  typedef struct {
    logic         flush;
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic [2:0]   cnt;
    logic [W-1:0] od;
    logic         err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic f, input logic v, input logic r, input logic [W-1:0] d,
                     input logic [2:0] c, input logic [W-1:0] o, input logic e);
    vec_t x;
    x.flush = f; x.valid = v; x.ready = r; x.data = d;
    x.cnt = c; x.od = o; x.err = e;
    vq.push_back(x);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Checks every observable output of the depth-4 instance against an expected occupancy.
  task automatic check_state(input string tag, input logic [2:0] c, input logic [W-1:0] o,
                             input logic e);
    check({tag, " count"}, W'(count), W'(c));
    check({tag, " out_valid"}, W'(out_valid), W'(c != 3'd0));
    check({tag, " empty"}, W'(empty), W'(c == 3'd0));
    check({tag, " full"}, W'(full), W'(c == 3'd4));
    check({tag, " in_ready"}, W'(in_ready), W'(c != 3'd4));
    check({tag, " out_data"}, out_data, o);
    check({tag, " err"}, W'(err), W'(e));
  endtask

  task automatic drive(input logic f, input logic v, input logic r, input logic [W-1:0] d);
    flush = f; in_valid = v; out_ready = r; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = W'(32'hDEAD);
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    check_state("reset", 3'd0, '0, 1'b0);

    // Fill, drain, empty push+pop, full with simultaneous pop, then drain.
    add(0, 1, 0, W'(1),     3'd1, W'(1),     0);
    add(0, 1, 0, W'(2),     3'd2, W'(1),     0);
    add(0, 1, 0, W'(3),     3'd3, W'(1),     0);
    add(0, 1, 0, W'(4),     3'd4, W'(1),     0);
    add(0, 0, 1, '0,        3'd3, W'(2),     0);
    add(0, 0, 1, '0,        3'd2, W'(3),     0);
    add(0, 0, 1, '0,        3'd1, W'(4),     0);
    add(0, 0, 1, '0,        3'd0, '0,        0);
    add(0, 1, 1, W'(8'h10), 3'd1, W'(8'h10), 0);
    add(0, 1, 1, W'(8'h11), 3'd1, W'(8'h11), 0);
    add(0, 1, 0, W'(8'h12), 3'd2, W'(8'h11), 0);
    add(0, 1, 0, W'(8'h13), 3'd3, W'(8'h11), 0);
    add(0, 1, 0, W'(8'h14), 3'd4, W'(8'h11), 0);
    add(0, 1, 1, W'(8'h15), 3'd3, W'(8'h12), 0);
    add(0, 1, 0, W'(8'h15), 3'd4, W'(8'h12), 0);
    add(0, 0, 1, '0,        3'd3, W'(8'h13), 0);
    add(0, 0, 1, '0,        3'd2, W'(8'h14), 0);
    add(0, 0, 1, '0,        3'd1, W'(8'h15), 0);
    add(0, 0, 1, '0,        3'd0, '0,        0);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].flush, vq[i].valid, vq[i].ready, vq[i].data);
      check_state($sformatf("vec%0d", i), vq[i].cnt, vq[i].od, vq[i].err);
    end

    // Flush mid-stream with a push in the flush cycle.
    drive(0, 1, 0, W'(8'h21));
    drive(0, 1, 0, W'(8'h22));
    drive(0, 1, 0, W'(8'h23));
    check_state("pre_flush", 3'd3, W'(8'h21), 1'b0);
    drive(1, 1, 0, W'(8'hFF));
    check_state("flush", 3'd0, '0, 1'b1);
    drive(0, 1, 0, W'(8'h55));
    check_state("post_flush_push", 3'd1, W'(8'h55), 1'b1);
    drive(0, 0, 1, '0);
    check_state("post_flush_pop", 3'd0, '0, 1'b1);

    // Misuse: valid dropped while full; sticky through flush, cleared by reset.
    do_reset();
    check_state("reset2", 3'd0, '0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, W'(i + 'h30));
    drive(0, 1, 0, W'(8'h34));
    check_state("full_pending", 3'd4, W'(8'h30), 1'b0);
    drive(0, 0, 0, '0);
    check_state("misuse", 3'd4, W'(8'h30), 1'b1);
    drive(1, 0, 0, '0);
    check_state("misuse_flush", 3'd0, '0, 1'b1);
    do_reset();
    check_state("reset3", 3'd0, '0, 1'b0);

    // Depth-3 wrap: keep two entries, stream ten push+pop pairs.
    w_in_valid = 1'b1; w_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_in_data = W'(8'hA0 + i);
      @(posedge clk); #1;
    end
    check("wrap prefill count", W'(w_count), W'(2));
    w_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w_in_data = W'(8'hA2 + i);
      check($sformatf("wrap out%0d", i), w_out_data, W'(8'hA0 + i));
      @(posedge clk); #1;
      check($sformatf("wrap count%0d", i), W'(w_count), W'(2));
    end
    w_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("wrap tail%0d", i), w_out_data, W'(8'hAA + i));
      @(posedge clk); #1;
    end
    check("wrap empty", W'(w_empty), W'(1));
    check("wrap err", W'(w_err), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
